// File: rtl/serial_sub_golden_if.sv
//============================================================================
// Module   : serial_sub_golden_if
// Brief    : Bit-serial subtractor stream bundle (bit inputs, result outputs)
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface serial_sub_golden_if;
    logic en;
    logic start;
    logic A;
    logic B;
    logic Bin;
    logic diff;
    logic diff_valid;
    logic word_done;
    logic Bout;

    modport master (
        output en, start, A, B, Bin,
        input  diff, diff_valid, word_done, Bout
    );

    modport slave (
        input  en, start, A, B, Bin,
        output diff, diff_valid, word_done, Bout
    );
endinterface

`default_nettype wire

// File: rtl/serial_sub_golden.sv
//============================================================================
// Module   : serial_sub_golden
// Brief    : Registered bit-serial LSB-first full subtractor, A - B - Bin
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_sub_golden #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_sub_golden_if.slave   bus
);

    localparam int                 c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_a, r_b, r_bin, r_en, r_start;
    logic                 r_borrow, w_borrow_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic                 r_diff, w_diff_nxt;
    logic                 r_dv, w_dv_nxt;
    logic                 r_wd, w_wd_nxt;
    logic                 r_bout, w_bout_nxt;

    logic                 w_bin_eff;
    logic                 w_d;
    logic                 w_bo;
    logic                 w_active;
    logic [c_CNT_W-1:0]   w_pos;
    logic                 w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_bin   <= 1'b0;
            r_en    <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_bin   <= bus.Bin;
            r_en    <= bus.en;
            r_start <= bus.start;
        end
    end

    // A start bit restarts the word from bit 0 even while a word is in flight.
    assign w_bin_eff = r_start ? r_bin : r_borrow;
    assign w_d       = r_a ^ r_b ^ w_bin_eff;
    assign w_bo      = (~r_a & r_b) | (~(r_a ^ r_b) & w_bin_eff);
    assign w_active  = r_en & (r_start | (r_state == RUN));
    assign w_pos     = r_start ? '0 : r_cnt;
    assign w_last    = (w_pos == c_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_borrow_nxt = r_borrow;
        w_diff_nxt   = r_diff;
        w_dv_nxt     = 1'b0;
        w_wd_nxt     = 1'b0;
        w_bout_nxt   = r_bout;
        if (w_active) begin
            w_state_nxt  = w_last ? IDLE : RUN;
            w_cnt_nxt    = w_pos + c_CNT_W'(1);
            w_borrow_nxt = w_bo;
            w_diff_nxt   = w_d;
            w_dv_nxt     = 1'b1;
            w_wd_nxt     = w_last;
            if (w_last) begin
                w_bout_nxt = w_bo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_diff   <= 1'b0;
            r_dv     <= 1'b0;
            r_wd     <= 1'b0;
            r_bout   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_borrow <= w_borrow_nxt;
            r_diff   <= w_diff_nxt;
            r_dv     <= w_dv_nxt;
            r_wd     <= w_wd_nxt;
            r_bout   <= w_bout_nxt;
        end
    end

    assign bus.diff       = r_diff;
    assign bus.diff_valid = r_dv;
    assign bus.word_done  = r_wd;
    assign bus.Bout       = r_bout;

endmodule

`default_nettype wire

// File: doc/serial_sub_golden.md
# serial_sub_golden

Bit-serial, LSB-first full subtractor computing A − B − Bin over WIDTH-bit words, one bit per enabled clock. It is the subtract-side counterpart of the registered full-adder datapath: inputs are registered, difference and borrow are computed from the registered inputs, and results are registered again before leaving the block. A word counter and a borrow register carry state across bits and frame each word with a start marker and a done pulse.

## Interface
- WIDTH, 8, bits per word (≥1)
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  reset; synchronous, active-low, sampled on posedge clk
- en  input  1  bit valid; current A/B bit belongs to a word
- start  input  1  with en: this is bit 0 (LSB) of a new word
- A  input  1  minuend bit
- B  input  1  subtrahend bit
- Bin  input  1  initial borrow for the word, sampled only with start
- diff  output  1  difference bit
- diff_valid  output  1  diff carries a new bit this cycle
- word_done  output  1  one-cycle pulse with the MSB difference bit
- Bout  output  1  final borrow of the last completed word

## Operation
- Stage 1 (input regs): a_q, b_q, bin_q, en_q, start_q <= A, B, Bin, en, start every cycle.
- Compute from stage 1: bin_eff = start_q ? bin_q : borrow_r; d = a_q ^ b_q ^ bin_eff; bo = (~a_q & b_q) | (~(a_q ^ b_q) & bin_eff).
- State: borrow_r (1b), cnt (ceil(log2(WIDTH+1)) bits), busy (1b).
- States: IDLE (busy=0), RUN (busy=1).
- active = en_q & (start_q | busy). start_q with en_q always begins a new word from any state, aborting any word in progress without a word_done.
- pos = start_q ? 0 : cnt; last = (pos == WIDTH−1).
- Active cycle: diff <= d; diff_valid <= 1; borrow_r <= bo; cnt <= pos+1; busy <= ~last; word_done <= last; if last, Bout <= bo.
- Inactive cycle (en_q=0, or en_q=1 without start_q while IDLE): diff_valid <= 0, word_done <= 0; diff, Bout, borrow_r, cnt, busy hold. en low mid-word stalls the word with no state loss.
- After word_done, block is IDLE; further en without start is ignored.
- WIDTH=1: every start bit is also last; word_done on every started bit.
- Result equals (A − B − Bin) mod 2^WIDTH; Bout=1 iff A < B + Bin (unsigned).

## Timing
- Reset (rst_n=0 at posedge): all stage-1 regs, diff, diff_valid, word_done, Bout, borrow_r, cnt, busy = 0. Reset mid-word discards the word; no word_done.
- Latency: bit presented before posedge N is sampled at N; diff/diff_valid registered at N+1 (two edges, same as the adder datapath).
- Back-to-back words: start may be asserted on the bit immediately after the previous word's MSB; zero bubble.
- word_done and the MSB diff appear in the same cycle; Bout updates in that cycle and holds until the next word_done or reset.
- start with en=0 is ignored.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, Bin=0, en continuous, start on bit 0 -> diff bits LSB-first = 0x1E on 8 consecutive diff_valid cycles, word_done on 8th, Bout=0; first diff_valid two edges after first bit presented.
- A=0x10, B=0x20, Bin=0 -> diff=0xF0, Bout=1; then immediately A=0x00, B=0x00, Bin=1 -> diff=0xFF, Bout=1, no idle cycle between words.
- A=0xFF, B=0x01 with en low for 3 cycles after bit 3 -> diff=0xFE, Bout=0; diff_valid low exactly 3 cycles, word_done only after 8 valid bits.
- Start a word, after 4 bits assert start with new A=0x03, B=0x01 -> first word produces no word_done; new word gives diff=0x02, Bout=0.
- rst_n low for one cycle after bit 5 -> all outputs 0 next cycle; subsequent en without start produces no diff_valid; next start word computes correctly.
- en pulses without start from reset -> diff_valid, word_done stay 0, Bout stays 0.
